// File: rtl/mult_sequencer.sv
// Control FSM for the shift-add signed multiplier datapath.
// Turns Execute / ClearXA_LoadB levels into one-cycle datapath commands.
module mult_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_execute,
  input  logic          i_clrxa_ldb,
  input  logic          i_m,
  output logic          o_ld_b,
  output logic          o_clr_xa,
  output logic          o_add,
  output logic          o_sub,
  output logic          o_shift,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_step
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_count;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_count  = r_count;
    o_ld_b   = 1'b0;
    o_clr_xa = 1'b0;
    o_add    = 1'b0;
    o_sub    = 1'b0;
    o_shift  = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_step   = '0;
    unique case (r_state)
      IDLE: begin
        w_count = '0;
        if (i_clrxa_ldb) begin
          o_ld_b   = 1'b1;
          o_clr_xa = 1'b1;
        end else if (i_execute) begin
          w_next = CLR;
        end
      end
      CLR: begin
        o_clr_xa = 1'b1;
        o_busy   = 1'b1;
        w_count  = '0;
        w_next   = ADD;
      end
      ADD: begin
        o_busy = 1'b1;
        o_step = r_count;
        // Sign-bit weight is negative, so the last partial product subtracts
        if (i_m) begin
          if (r_count == LAST) o_sub = 1'b1;
          else                 o_add = 1'b1;
        end
        w_next = SHIFT;
      end
      SHIFT: begin
        o_shift = 1'b1;
        o_busy  = 1'b1;
        o_step  = r_count;
        if (r_count == LAST) begin
          w_next = HOLD;
        end else begin
          w_count = r_count + 1'b1;
          w_next  = ADD;
        end
      end
      HOLD: begin
        o_done = 1'b1;
        if (!i_execute) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (i_reset) begin
      o_ld_b   = 1'b0;
      o_clr_xa = 1'b0;
      o_add    = 1'b0;
      o_sub    = 1'b0;
      o_shift  = 1'b0;
      o_busy   = 1'b0;
      o_done   = 1'b0;
      o_step   = '0;
    end
  end

endmodule
